// File: rtl/neuron_block.sv
// neuron_block: 32 leaky integrate-and-fire neurons sharing one axon input.
//
// Axon events (a 32-bit connection row plus one signed weight) are integrated
// into every selected membrane potential with saturation. A time-step strobe
// fires every neuron at or above THRESHOLD, leaks the rest toward zero and
// publishes the spike vector.
//
// Ports:
//   wb_clk_i       clock, all state changes on its rising edge
//   wb_rst_i       synchronous active-low reset
//   conn_i         connection row of the offered axon event, bit n -> neuron n
//   weight_i       signed 9-bit weight of the offered axon event
//   axon_valid_i   axon event offered on conn_i/weight_i
//   axon_ready_o   block accepts an axon event this cycle
//   tick_i         single-cycle time-step strobe
//   spikes_o       fire flags of the most recent time step
//   spikes_valid_o one-cycle strobe, spikes_o has just been updated
//   v_sel_i        potential readback select
//   v_o            potential of neuron v_sel_i (combinational)
//   tick_ovf_o     sticky, a time step was dropped
module neuron_block #(
    parameter logic signed [15:0] THRESHOLD = 16'sd256,
    parameter logic [15:0]        LEAK      = 16'd1,
    parameter logic signed [15:0] V_RESET   = 16'sd0
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] conn_i,
    input  logic [8:0]  weight_i,
    input  logic        axon_valid_i,
    output logic        axon_ready_o,
    input  logic        tick_i,
    output logic [31:0] spikes_o,
    output logic        spikes_valid_o,
    input  logic [4:0]  v_sel_i,
    output logic [15:0] v_o,
    output logic        tick_ovf_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INTEG = 2'd1,
        ST_FIRE  = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic               axon_ready_s;
    logic               accept_s;
    logic               tick_pending_r;
    logic               tick_ovf_r;
    logic [31:0]        conn_r;
    logic signed [16:0] weight_r;
    logic [31:0]        spikes_r;
    logic               spikes_valid_r;
    logic [31:0]        spike_s;
    logic signed [15:0] v_r       [0:31];
    logic signed [15:0] v_integ_s [0:31];
    logic signed [15:0] v_fire_s  [0:31];

    // Add a 17-bit signed weight to a potential, clamping to the 16-bit range.
    function automatic logic signed [15:0] sat_add(input logic signed [15:0] v,
                                                   input logic signed [16:0] w);
        logic signed [17:0] sum;
        sum = {{2{v[15]}}, v} + {w[16], w};
        if (sum > 18'sd32767) begin
            return 16'sh7FFF;
        end else if (sum < -18'sd32768) begin
            return 16'sh8000;
        end else begin
            return sum[15:0];
        end
    endfunction

    // Move a potential LEAK units toward zero without crossing it.
    function automatic logic signed [15:0] leak_step(input logic signed [15:0] v);
        logic signed [17:0] t;
        if (v > 16'sd0) begin
            t = {{2{v[15]}}, v} - {2'b00, LEAK};
            if (t > 18'sd0) begin
                return t[15:0];
            end else begin
                return 16'sd0;
            end
        end else if (v < 16'sd0) begin
            t = {{2{v[15]}}, v} + {2'b00, LEAK};
            if (t < 18'sd0) begin
                return t[15:0];
            end else begin
                return 16'sd0;
            end
        end else begin
            return v;
        end
    endfunction

    // State register.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a pending tick always wins over a new axon event.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (tick_pending_r) begin
                    state_next_s = ST_FIRE;
                end else if (accept_s) begin
                    state_next_s = ST_INTEG;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_INTEG: state_next_s = ST_IDLE;
            ST_FIRE:  state_next_s = ST_OUT;
            ST_OUT:   state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Output decode; a tick strobe arriving in IDLE also blocks the event so
    // that the time step is always processed before a same-cycle event.
    always_comb begin
        axon_ready_s = 1'b0;
        if ((state_r == ST_IDLE) && !tick_pending_r && !tick_i) begin
            axon_ready_s = 1'b1;
        end else begin
            axon_ready_s = 1'b0;
        end
    end

    assign accept_s = axon_valid_i && axon_ready_s;

    // Tick bookkeeping: FIRE consumes the pending tick, so a tick seen in FIRE
    // or OUT starts a fresh pending step rather than overflowing.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            tick_pending_r <= 1'b0;
            tick_ovf_r     <= 1'b0;
        end else begin
            if (state_r == ST_FIRE) begin
                tick_pending_r <= tick_i;
            end else if (tick_i) begin
                tick_pending_r <= 1'b1;
            end else begin
                tick_pending_r <= tick_pending_r;
            end
            if (tick_i && tick_pending_r && (state_r != ST_FIRE) && (state_r != ST_OUT)) begin
                tick_ovf_r <= 1'b1;
            end else begin
                tick_ovf_r <= tick_ovf_r;
            end
        end
    end

    // Latch the accepted event; weight is sign-extended once here.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            conn_r   <= 32'd0;
            weight_r <= 17'sd0;
        end else if (accept_s) begin
            conn_r   <= conn_i;
            weight_r <= {{8{weight_i[8]}}, weight_i};
        end else begin
            conn_r   <= conn_r;
            weight_r <= weight_r;
        end
    end

    // Candidate potentials for integration and for the time step.
    always_comb begin
        spike_s = 32'd0;
        for (int n = 0; n < 32; n++) begin
            v_integ_s[n] = sat_add(v_r[n], weight_r);
            if (v_r[n] >= THRESHOLD) begin
                spike_s[n]  = 1'b1;
                v_fire_s[n] = V_RESET;
            end else begin
                v_fire_s[n] = leak_step(v_r[n]);
            end
        end
    end

    // Potential and spike registers; only INTEG and FIRE commit new values,
    // so a reset in either state discards the whole operation.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            for (int n = 0; n < 32; n++) begin
                v_r[n] <= 16'sd0;
            end
            spikes_r       <= 32'd0;
            spikes_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_INTEG: begin
                    for (int n = 0; n < 32; n++) begin
                        if (conn_r[n]) begin
                            v_r[n] <= v_integ_s[n];
                        end else begin
                            v_r[n] <= v_r[n];
                        end
                    end
                    spikes_r <= spikes_r;
                end
                ST_FIRE: begin
                    for (int n = 0; n < 32; n++) begin
                        v_r[n] <= v_fire_s[n];
                    end
                    spikes_r <= spike_s;
                end
                default: begin
                    spikes_r <= spikes_r;
                end
            endcase
            spikes_valid_r <= (state_next_s == ST_OUT);
        end
    end

    assign axon_ready_o   = axon_ready_s;
    assign spikes_o       = spikes_r;
    assign spikes_valid_o = spikes_valid_r;
    assign tick_ovf_o     = tick_ovf_r;
    assign v_o            = v_r[v_sel_i];

endmodule

// File: tb/tb_neuron_block.sv
// tb_neuron_block: directed bench for neuron_block. A transaction-level model
// (integer potentials, spec arithmetic) tracks the expected state; a negedge
// compare process checks every output each cycle, and literal checks pin the
// model at the key points of the scenario.
module tb_neuron_block;

    localparam int THR  = 256;
    localparam int LK   = 1;
    localparam int VRST = 0;

    logic        tb_clk;
    logic        wb_rst_i;
    logic [31:0] conn_i;
    logic [8:0]  weight_i;
    logic        axon_valid_i;
    logic        axon_ready_o;
    logic        tick_i;
    logic [31:0] spikes_o;
    logic        spikes_valid_o;
    logic [4:0]  v_sel_i;
    logic [15:0] v_o;
    logic        tick_ovf_o;

    int          mv [32];
    logic [31:0] mspk;
    logic        movf;
    logic        exp_ready;
    logic        exp_valid;
    logic        chk_en;
    int          n_checks;
    int          n_pass;

    neuron_block dut (
        .wb_clk_i       (tb_clk),
        .wb_rst_i       (wb_rst_i),
        .conn_i         (conn_i),
        .weight_i       (weight_i),
        .axon_valid_i   (axon_valid_i),
        .axon_ready_o   (axon_ready_o),
        .tick_i         (tick_i),
        .spikes_o       (spikes_o),
        .spikes_valid_o (spikes_valid_o),
        .v_sel_i        (v_sel_i),
        .v_o            (v_o),
        .tick_ovf_o     (tick_ovf_o)
    );

    // Free-running clock.
    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    // Hard time limit.
    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got running sim, required finish");
        $fatal(1, "watchdog");
    end

    function automatic int msat(input int x);
        if (x > 32767) return 32767;
        else if (x < -32768) return -32768;
        else return x;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 32; n++) mv[n] = 0;
        mspk      = 32'd0;
        movf      = 1'b0;
        exp_valid = 1'b0;
        exp_ready = 1'b1;
    endtask

    task automatic model_integ(input logic [31:0] c, input int w);
        for (int n = 0; n < 32; n++)
            if (c[n]) mv[n] = msat(mv[n] + w);
    endtask

    task automatic model_fire();
        mspk = 32'd0;
        for (int n = 0; n < 32; n++) begin
            if (mv[n] >= THR) begin
                mspk[n] = 1'b1;
                mv[n]   = VRST;
            end else if (mv[n] > 0) begin
                mv[n] = (mv[n] - LK > 0) ? mv[n] - LK : 0;
            end else if (mv[n] < 0) begin
                mv[n] = (mv[n] + LK < 0) ? mv[n] + LK : 0;
            end
        end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, got, exp);
    endtask

    task automatic clk1();
        @(posedge tb_clk);
        #1;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge tb_clk) begin
        if (chk_en) begin
            int got_v;
            got_v = int'($signed(v_o));
            n_checks += 5;
            if (axon_ready_o === exp_ready) n_pass++;
            else $display("FAIL ready @%0t: got %b, required %b", $time, axon_ready_o, exp_ready);
            if (spikes_valid_o === exp_valid) n_pass++;
            else $display("FAIL spikes_valid @%0t: got %b, required %b", $time, spikes_valid_o, exp_valid);
            if (spikes_o === mspk) n_pass++;
            else $display("FAIL spikes @%0t: got %h, required %h", $time, spikes_o, mspk);
            if (tick_ovf_o === movf) n_pass++;
            else $display("FAIL tick_ovf @%0t: got %b, required %b", $time, tick_ovf_o, movf);
            if (got_v == mv[v_sel_i]) n_pass++;
            else $display("FAIL v[%0d] @%0t: got %0d, required %0d", v_sel_i, $time, got_v, mv[v_sel_i]);
        end
    end

    task automatic send_event(input logic [31:0] c, input int w);
        conn_i = c; weight_i = w[8:0]; axon_valid_i = 1'b1; exp_ready = 1'b1;
        clk1();
        axon_valid_i = 1'b0; exp_ready = 1'b0;
        clk1();
        model_integ(c, w); exp_ready = 1'b1;
    endtask

    task automatic do_tick();
        tick_i = 1'b1; exp_ready = 1'b0;
        clk1();
        tick_i = 1'b0;
        clk1();
        clk1();
        model_fire(); exp_valid = 1'b1;
        clk1();
        exp_valid = 1'b0; exp_ready = 1'b1;
    endtask

    task automatic lit_v(input string name, input int sel, input int exp);
        clk1();
        v_sel_i = sel[4:0];
        #1;
        chk(name, int'($signed(v_o)), exp);
    endtask

    task automatic sweep();
        for (int s = 0; s < 32; s++) begin
            clk1();
            v_sel_i = s[4:0];
        end
    endtask

    initial begin
        n_checks = 0; n_pass = 0; chk_en = 1'b0;
        wb_rst_i = 1'b0; conn_i = 32'd0; weight_i = 9'd0;
        axon_valid_i = 1'b0; tick_i = 1'b0; v_sel_i = 5'd0;
        model_reset();
        clk1();
        clk1();
        wb_rst_i = 1'b1;
        chk_en   = 1'b1;

        // Reset state.
        chk("rst_spikes", int'(spikes_o), 0);
        chk("rst_ovf", int'(tick_ovf_o), 0);
        chk("rst_ready", int'(axon_ready_o), 1);

        // Three +100 events on neurons 0 and 2.
        for (int i = 0; i < 3; i++) send_event(32'h0000_0005, 100);
        lit_v("v0_300", 0, 300);
        lit_v("v1_0", 1, 0);
        lit_v("v2_300", 2, 300);

        // Both fire.
        do_tick();
        chk("spk_5", int'(spikes_o), 5);
        lit_v("v0_fired", 0, 0);
        lit_v("v2_fired", 2, 0);
        sweep();

        // Sub-threshold leak, then negative leak.
        send_event(32'h0000_0008, 250);
        do_tick();
        chk("spk_none", int'(spikes_o), 0);
        lit_v("v3_249", 3, 249);
        send_event(32'h0000_0008, -255);
        lit_v("v3_m6", 3, -6);
        do_tick();
        lit_v("v3_m5", 3, -5);

        // Saturation at both rails on neuron 31.
        for (int i = 0; i < 200; i++) send_event(32'h8000_0000, 255);
        lit_v("v31_max", 31, 32767);
        do_tick();
        chk("spk_31", int'(spikes_o == 32'h8000_0000), 1);
        for (int i = 0; i < 300; i++) send_event(32'h8000_0000, -256);
        lit_v("v31_min", 31, -32768);
        do_tick();
        lit_v("v31_leak", 31, -32767);

        // Tick and event in the same IDLE cycle: tick first.
        v_sel_i = 5'd4;
        tick_i = 1'b1; axon_valid_i = 1'b1; conn_i = 32'h0000_0010; weight_i = 9'd50;
        exp_ready = 1'b0;
        clk1();
        tick_i = 1'b0;
        clk1();
        clk1();
        model_fire(); exp_valid = 1'b1;
        clk1();
        exp_valid = 1'b0; exp_ready = 1'b1;
        clk1();
        axon_valid_i = 1'b0; exp_ready = 1'b0;
        clk1();
        model_integ(32'h0000_0010, 50); exp_ready = 1'b1;
        lit_v("v4_50", 4, 50);

        // A tick during FIRE re-arms without overflow.
        tick_i = 1'b1; exp_ready = 1'b0;
        clk1();
        tick_i = 1'b0;
        clk1();
        tick_i = 1'b1;
        clk1();
        model_fire(); exp_valid = 1'b1; tick_i = 1'b0;
        clk1();
        exp_valid = 1'b0;
        clk1();
        clk1();
        model_fire(); exp_valid = 1'b1;
        clk1();
        exp_valid = 1'b0; exp_ready = 1'b1;
        chk("ovf_still_0", int'(tick_ovf_o), 0);

        // Three ticks while busy.
        axon_valid_i = 1'b1; conn_i = 32'h0000_0020; weight_i = 9'd10; exp_ready = 1'b1;
        clk1();
        axon_valid_i = 1'b0; tick_i = 1'b1; exp_ready = 1'b0;
        clk1();
        model_integ(32'h0000_0020, 10);
        clk1();
        movf = 1'b1;
        clk1();
        model_fire(); exp_valid = 1'b1; tick_i = 1'b0;
        clk1();
        exp_valid = 1'b0;
        clk1();
        clk1();
        model_fire(); exp_valid = 1'b1;
        clk1();
        exp_valid = 1'b0; exp_ready = 1'b1;
        chk("ovf_set", int'(tick_ovf_o), 1);

        // Reset in the middle of INTEG.
        axon_valid_i = 1'b1; conn_i = 32'hFFFF_FFFF; weight_i = 9'd100; exp_ready = 1'b1;
        clk1();
        axon_valid_i = 1'b0; wb_rst_i = 1'b0; exp_ready = 1'b0;
        clk1();
        model_reset();
        wb_rst_i = 1'b1;
        chk("ready_after_rst", int'(axon_ready_o), 1);
        chk("ovf_after_rst", int'(tick_ovf_o), 0);
        lit_v("v0_after_rst", 0, 0);
        sweep();

        clk1();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
